// File: rtl/coriolis_stream_sink.sv
// Terminal sink for a coriolis kernel stream: accepts results into a 16-deep FIFO
// and drains them to a request/grant memory-write port at consecutive addresses.
module coriolis_stream_sink #(
    parameter int unsigned STREAMW = 34,
    parameter int unsigned AW      = 4,
    parameter int unsigned ADDRW   = 16,
    parameter int unsigned NW      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NW-1:0]      n_elems,
    input  logic [ADDRW-1:0]   base_addr,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1_s0,
    output logic               oready,
    output logic               mem_wreq,
    output logic [ADDRW-1:0]   mem_waddr,
    output logic [STREAMW-1:0] mem_wdata,
    input  logic               mem_wgnt,
    output logic               busy,
    output logic               done,
    output logic [NW-1:0]      count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [NW-1:0]      n_q, accepted, written;
    logic [ADDRW-1:0]   base_q;
    logic [STREAMW-1:0] fifo_mem [2**AW];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, active, push, pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign active    = (state == RUN) || (state == DRAIN);
    assign oready    = (state == RUN) && !fifo_full && (accepted < n_q);
    assign mem_wreq  = active && !fifo_empty;
    assign push      = ivalid && oready;
    assign pop       = mem_wreq && mem_wgnt;
    assign mem_waddr = base_q + ADDRW'(written);
    assign mem_wdata = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = active;
    assign done      = (state == DONE);
    assign count     = written;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (n_elems == '0) ? DONE : RUN;
            RUN:     if (push && (accepted + NW'(1) == n_q)) state_nxt = DRAIN;
            DRAIN:   if (pop && (written + NW'(1) == n_q)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            n_q      <= '0;
            base_q   <= '0;
            accepted <= '0;
            written  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                n_q      <= n_elems;
                base_q   <= base_addr;
                accepted <= '0;
                written  <= '0;
            end else begin
                if (push) accepted <= accepted + NW'(1);
                if (pop)  written  <= written + NW'(1);
            end
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= in1_s0;
    end

endmodule

// File: tb/tb_coriolis_stream_sink.sv
// Directed bench for coriolis_stream_sink: streaming, backpressure, zero-length,
// address wrap, mid-job reset and ignored start.
`timescale 1ns/1ps
module tb_coriolis_stream_sink;

    localparam int STREAMW = 34;
    localparam int ADDRW   = 16;
    localparam int NW      = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               ivalid = 1'b0;
    logic               mem_wgnt = 1'b0;
    logic [NW-1:0]      n_elems = '0;
    logic [ADDRW-1:0]   base_addr = '0;
    logic [STREAMW-1:0] in1_s0 = '0;
    logic               oready, mem_wreq, busy, done;
    logic [ADDRW-1:0]   mem_waddr;
    logic [STREAMW-1:0] mem_wdata;
    logic [NW-1:0]      count;

    int checks = 0;
    int errors = 0;

    logic [ADDRW-1:0]   wr_addr[$];
    logic [STREAMW-1:0] wr_data[$];
    int   pushes, dones, first_done, ready_full, ready_over, wreq_seen, ready_seen, pushes_at_gnt;
    logic busy0, ready0, busy_at_done, ready_pre_gnt;

    always #5 clk = ~clk;

    coriolis_stream_sink #(
        .STREAMW(STREAMW),
        .AW(4),
        .ADDRW(ADDRW),
        .NW(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_elems(n_elems), .base_addr(base_addr),
        .ivalid(ivalid), .in1_s0(in1_s0), .oready(oready), .mem_wreq(mem_wreq),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wgnt(mem_wgnt),
        .busy(busy), .done(done), .count(count)
    );

    // Drives one job and records what crosses both handshakes; inputs change on negedge.
    task automatic run_job(input logic [NW-1:0] n, input logic [ADDRW-1:0] b, input logic [1:0] tag,
                           input int ncyc, input int gnt_delay, input int ival_cyc,
                           input int ign_cyc, input int abort_at);
        wr_addr.delete(); wr_data.delete();
        pushes = 0; dones = 0; first_done = -1; ready_full = 0; ready_over = 0;
        wreq_seen = 0; ready_seen = 0; pushes_at_gnt = -1;
        busy0 = 1'b0; ready0 = 1'b0; busy_at_done = 1'bx; ready_pre_gnt = 1'bx;
        @(negedge clk);
        start = 1'b1; n_elems = n; base_addr = b;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (abort_at != 0 && wr_addr.size() == abort_at) break;
            if (c == 0) begin busy0 = busy; ready0 = oready; end
            start = (c == ign_cyc);
            if (c == ign_cyc) begin n_elems = n + 16'd5; base_addr = 16'h0700; end
            if (done) begin
                dones++;
                if (first_done < 0) begin first_done = c; busy_at_done = busy; end
            end
            if (c == gnt_delay) pushes_at_gnt = pushes;
            if (c == gnt_delay - 1) ready_pre_gnt = oready;
            ivalid   = (c < ival_cyc);
            in1_s0   = {tag, 32'(pushes)};
            mem_wgnt = (c >= gnt_delay);
            if (oready) ready_seen++;
            if (mem_wreq) wreq_seen++;
            if (oready && (pushes - wr_addr.size()) >= 16) ready_full++;
            if (oready && pushes >= int'(n)) ready_over++;
            if (ivalid && oready) pushes++;
            if (mem_wreq && mem_wgnt) begin
                wr_addr.push_back(mem_waddr);
                wr_data.push_back(mem_wdata);
            end
        end
        start = 1'b0; ivalid = 1'b0; mem_wgnt = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({oready, mem_wreq, busy, done, mem_waddr, mem_wdata, count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b wreq=%0b busy=%0b done=%0b addr=%h data=%h cnt=%0d want all 0",
                     oready, mem_wreq, busy, done, mem_waddr, mem_wdata, count);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oready, mem_wreq, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0000", {oready, mem_wreq, busy, done});
        end
    endtask

    task automatic test_stream;
        logic [ADDRW-1:0] ea;
        run_job(16'd8, 16'h0100, 2'b00, 30, 0, 30, -1, 0);
        checks++;
        if ({busy0, ready0} !== 2'b11) begin
            errors++; $display("FAIL stream_start_latency got busy/ready=%b want 11", {busy0, ready0});
        end
        checks++;
        if (wr_addr.size() != 8) begin
            errors++; $display("FAIL stream_nwrites got %0d want 8", wr_addr.size());
        end
        for (int i = 0; i < 8; i++) begin
            ea = 16'h0100 + 16'(i);
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== ea || wr_data[i] !== 34'(i)) begin
                errors++;
                $display("FAIL stream_write[%0d] got addr=%h data=%h want addr=%h data=%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx,
                         (i < wr_data.size()) ? wr_data[i] : 34'hx, ea, 34'(i));
            end
        end
        checks++;
        if (first_done != 9 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL stream_done_cycle got %0d busy=%b want 9 busy=0", first_done, busy_at_done);
        end
        checks++;
        if (dones != 1 || count !== 16'd8 || busy !== 1'b0) begin
            errors++; $display("FAIL stream_end got dones=%0d count=%0d busy=%b want 1 8 0", dones, count, busy);
        end
        checks++;
        if (ready_over != 0 || pushes != 8) begin
            errors++; $display("FAIL stream_accepts got pushes=%0d over=%0d want 8 0", pushes, ready_over);
        end
    endtask

    task automatic test_backpressure;
        run_job(16'd20, 16'h0200, 2'b10, 80, 30, 80, -1, 0);
        checks++;
        if (pushes_at_gnt != 16 || ready_pre_gnt !== 1'b0) begin
            errors++; $display("FAIL bp_fill got pushes=%0d ready=%b want 16 0", pushes_at_gnt, ready_pre_gnt);
        end
        checks++;
        if (ready_full != 0) begin
            errors++; $display("FAIL bp_ready_while_full got %0d cycles want 0", ready_full);
        end
        checks++;
        if (wr_addr.size() != 20 || pushes != 20) begin
            errors++; $display("FAIL bp_counts got writes=%0d pushes=%0d want 20 20", wr_addr.size(), pushes);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== 16'h0200 + 16'(i) || wr_data[i] !== {2'b10, 32'(i)}) begin
                errors++;
                $display("FAIL bp_write[%0d] got addr=%h data=%h want addr=%h data=%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx,
                         (i < wr_data.size()) ? wr_data[i] : 34'hx, 16'h0200 + 16'(i), {2'b10, 32'(i)});
            end
        end
        checks++;
        if (dones != 1 || count !== 16'd20) begin
            errors++; $display("FAIL bp_end got dones=%0d count=%0d want 1 20", dones, count);
        end
    endtask

    task automatic test_zero_length;
        run_job(16'd0, 16'h0800, 2'b01, 6, 0, 6, -1, 0);
        checks++;
        if (first_done != 0 || busy_at_done !== 1'b0 || dones != 1) begin
            errors++; $display("FAIL zero_done got cyc=%0d busy=%b dones=%0d want 0 0 1", first_done, busy_at_done, dones);
        end
        checks++;
        if (wreq_seen != 0 || ready_seen != 0 || pushes != 0) begin
            errors++; $display("FAIL zero_quiet got wreq=%0d ready=%0d pushes=%0d want 0 0 0", wreq_seen, ready_seen, pushes);
        end
        checks++;
        if (count !== 16'd0) begin
            errors++; $display("FAIL zero_count got %0d want 0", count);
        end
    endtask

    task automatic test_wrap;
        logic [ADDRW-1:0] exp_a [4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run_job(16'd4, 16'hFFFE, 2'b11, 20, 0, 10, -1, 0);
        checks++;
        if (pushes != 4 || ready_over != 0) begin
            errors++; $display("FAIL wrap_accepts got pushes=%0d over=%0d want 4 0", pushes, ready_over);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== exp_a[i] || wr_data[i] !== {2'b11, 32'(i)}) begin
                errors++;
                $display("FAIL wrap_write[%0d] got addr=%h want %h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx, exp_a[i]);
            end
        end
        checks++;
        if (dones != 1 || count !== 16'd4) begin
            errors++; $display("FAIL wrap_end got dones=%0d count=%0d want 1 4", dones, count);
        end
    endtask

    task automatic test_reset_restart;
        run_job(16'd10, 16'h0300, 2'b01, 40, 0, 40, -1, 5);
        checks++;
        if (wr_addr.size() != 5 || dones != 0) begin
            errors++; $display("FAIL rr_prefix got writes=%0d dones=%0d want 5 0", wr_addr.size(), dones);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({oready, mem_wreq, busy, done, mem_waddr, mem_wdata, count} !== '0) begin
            errors++;
            $display("FAIL rr_async_reset got rdy=%0b wreq=%0b busy=%0b done=%0b addr=%h data=%h cnt=%0d want all 0",
                     oready, mem_wreq, busy, done, mem_waddr, mem_wdata, count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oready, mem_wreq, busy, done} !== 4'b0) begin
            errors++; $display("FAIL rr_idle got %b want 0000", {oready, mem_wreq, busy, done});
        end
        run_job(16'd3, 16'h0400, 2'b01, 20, 0, 20, -1, 0);
        checks++;
        if (wr_addr.size() != 3 || count !== 16'd3 || dones != 1) begin
            errors++; $display("FAIL rr_restart got writes=%0d count=%0d dones=%0d want 3 3 1", wr_addr.size(), count, dones);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== 16'h0400 + 16'(i) || wr_data[i] !== {2'b01, 32'(i)}) begin
                errors++;
                $display("FAIL rr_write[%0d] got addr=%h data=%h want addr=%h data=%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx,
                         (i < wr_data.size()) ? wr_data[i] : 34'hx, 16'h0400 + 16'(i), {2'b01, 32'(i)});
            end
        end
    endtask

    task automatic test_ignored_start;
        run_job(16'd6, 16'h0500, 2'b10, 30, 0, 30, 2, 0);
        checks++;
        if (wr_addr.size() != 6 || count !== 16'd6 || dones != 1 || first_done != 7) begin
            errors++;
            $display("FAIL ign_job got writes=%0d count=%0d dones=%0d done_cyc=%0d want 6 6 1 7",
                     wr_addr.size(), count, dones, first_done);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== 16'h0500 + 16'(i) || wr_data[i] !== {2'b10, 32'(i)}) begin
                errors++;
                $display("FAIL ign_write[%0d] got addr=%h want %h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx, 16'h0500 + 16'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_length();
        test_wrap();
        test_reset_restart();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
